pio_s1_master: RTL
==================

// Module: pio_s1_master
// PURPOSE
//  Avalon-MM initiator for the PIO "s1" slave port; the driving end of the led_pio_s1_* bus.
//  Serialises host commands (valid/ready) into single-cycle chipselect accesses and returns read data.
//  Includes an auto-walk mode: a prescaled one-hot LED pattern written to PIO data register when host idle.
//  Sits between a controller/FSM fabric and the PIO slave inside the DSD system.
// PARAMETERS
//  READ_LATENCY  1      cycles from chipselect-high cycle to readdata valid (legal 0..3)
//  LED_W         8      width of walking pattern (zero-extended to 32b on writedata)
//  PRESCALE      50000  clk cycles per auto-walk step (>=2)
//  PRESCALE_W    16     prescaler counter width; must hold PRESCALE-1
// PORTS
//  clk_clk          in   1   system clock, all logic rising-edge
//  reset_reset_n    in   1   asynchronous active-low reset
//  cmd_valid        in   1   host command present
//  cmd_ready        out  1   block accepts command this cycle
//  cmd_write        in   1   1=write, 0=read
//  cmd_addr         in   2   PIO register offset
//  cmd_wdata        in   32  write data
//  rsp_valid        out  1   one-cycle pulse: rsp_rdata valid (reads only)
//  rsp_rdata        out  32  captured read data
//  auto_en          in   1   enable auto-walk writes
//  s1_address       out  2   to PIO s1 address
//  s1_chipselect    out  1   to PIO s1 chipselect
//  s1_write_n       out  1   to PIO s1 write_n (active low)
//  s1_writedata     out  32  to PIO s1 writedata
//  s1_readdata      in   32  from PIO s1 readdata
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, cmd_ready=0, rsp_valid=0, rsp_rdata=0, s1_chipselect=0,
//   s1_write_n=1, s1_address=0, s1_writedata=0, prescaler=0, tick_pend=0, pattern=1 (bit0).
//  All s1_* outputs and rsp_* registered. cmd_ready = (state==IDLE) & !tick_win (combinational).
//  FSM: IDLE -> ACCESS -> [WAIT x READ_LATENCY] -> RESP -> IDLE (reads); IDLE -> ACCESS -> IDLE (writes).
//   IDLE: accept on cmd_valid&cmd_ready at edge T; load address/data/write_n.
//   ACCESS (T+1): s1_chipselect=1 exactly one cycle; no waitrequest supported.
//   Read sample: s1_readdata captured at end of cycle T+1+READ_LATENCY into rsp_rdata.
//   RESP: rsp_valid=1 one cycle at T+2+READ_LATENCY; rsp_rdata held until next read capture.
//   Write throughput 1 per 2 cycles; read 1 per 3+READ_LATENCY cycles. No rsp for writes.
//  Outside ACCESS: s1_chipselect=0, s1_write_n=1; address/writedata hold last value.
//  Auto-walk: prescaler counts 0..PRESCALE-1 while auto_en=1, wraps to 0 and sets tick_pend.
//   auto_en=0: prescaler forced 0, tick_pend cleared, pattern retained.
//   Arbitration in IDLE: tick_pend wins over cmd_valid (tick_win=tick_pend); issues write
//   addr 0, data {zeros,pattern}; on that ACCESS pattern rotates left (bit LED_W-1 -> bit0), tick_pend cleared.
//   Tick arriving while busy stays pending; a second tick while pending is dropped (no count).
//  Host writes to addr 0 do not modify pattern.
//  Reset mid-access: chipselect drops asynchronously; in-flight command lost, no rsp.
// STRUCTURE
//  Package pio_pkg: PIO_ADDR_DATA=2'd0, PIO_ADDR_DIR=2'd1, PIO_ADDR_IRQMASK=2'd2,
//   PIO_ADDR_EDGECAP=2'd3; state enum {IDLE,ACCESS,WAIT,RESP}.
//  Sub-module pio_tick_gen (PRESCALE, PRESCALE_W): clk, reset_n, en -> 1-cycle tick pulse.
//  Top holds FSM, latency counter (2b), pattern register, output registers.
// TESTING
//  1 Reset: assert reset_reset_n=0 mid-ACCESS -> s1_chipselect=0 same cycle, all outputs at reset values.
//  2 Write addr0 data 0x000000A5 -> one chipselect cycle at T+1, write_n=0, writedata=0xA5, no rsp_valid.
//  3 Read addr1, model returns 0x0000003C with READ_LATENCY=1 -> rsp_valid pulse at T+3, rsp_rdata=0x3C.
//  4 Back-to-back cmd_valid held high, 4 writes -> cmd_ready every 2nd cycle, 4 chipselect pulses, order kept.
//  5 auto_en=1, PRESCALE=4 -> writes 0x02,0x04,...,0x80,0x01 every 4 cycles; wrap 0x80->0x01 checked.
//  6 Tick coincident with cmd_valid in IDLE -> auto write (addr0) issued first, host cmd next, none lost.

Source files
------------

// File: rtl/pio_pkg.sv
// pio_pkg: PIO s1 register offsets and master FSM states.
package pio_pkg;
  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
endpackage

// File: rtl/pio_tick_gen.sv
// pio_tick_gen: one-cycle tick every PRESCALE clocks while enabled.
module pio_tick_gen #(
  parameter int PRESCALE   = 50000,
  parameter int PRESCALE_W = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);
  logic [PRESCALE_W-1:0] cnt;
  assign tick = en && cnt == PRESCALE_W'(PRESCALE - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= (!en || tick) ? '0 : cnt + PRESCALE_W'(1);
endmodule

// File: rtl/pio_s1_master.sv
// pio_s1_master: serialises host commands onto PIO s1 and interleaves auto-walk LED writes.
module pio_s1_master
  import pio_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int LED_W        = 8,
  parameter int PRESCALE     = 50000,
  parameter int PRESCALE_W   = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  input  logic        auto_en,
  output logic [1:0]  s1_address,
  output logic        s1_chipselect,
  output logic        s1_write_n,
  output logic [31:0] s1_writedata,
  input  logic [31:0] s1_readdata
);
  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY == 0 ? 0 : READ_LATENCY - 1);
  state_t state, state_nx;
  logic [1:0] lat;
  logic [LED_W-1:0] pattern, pattern_rot;
  logic tick, tick_pend, rst_done, take_auto, take_cmd, capture;
  pio_tick_gen #(.PRESCALE(PRESCALE), .PRESCALE_W(PRESCALE_W)) u_tick (
    .clk(clk_clk), .reset_n(reset_reset_n), .en(auto_en), .tick(tick)
  );
  assign pattern_rot = {pattern[LED_W-2:0], pattern[LED_W-1]};
  assign cmd_ready = rst_done && state == IDLE && !tick_pend;
  assign take_auto = rst_done && state == IDLE && tick_pend;
  assign take_cmd = cmd_valid && cmd_ready;
  // write_n low during ACCESS marks a write; reads continue into WAIT/RESP
  always_comb begin
    state_nx = state;
    capture = 1'b0;
    case (state)
      IDLE:   state_nx = (take_auto || take_cmd) ? ACCESS : IDLE;
      ACCESS: begin
        state_nx = !s1_write_n ? IDLE : (READ_LATENCY == 0) ? RESP : WAIT;
        capture = s1_write_n && READ_LATENCY == 0;
      end
      WAIT: begin
        state_nx = (lat == LAT_LAST) ? RESP : WAIT;
        capture = lat == LAT_LAST;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      state <= IDLE;
      rst_done <= 1'b0;
      lat <= 2'd0;
      tick_pend <= 1'b0;
      pattern <= LED_W'(1);
      s1_chipselect <= 1'b0;
      s1_write_n <= 1'b1;
      s1_address <= 2'd0;
      s1_writedata <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      state <= state_nx;
      rst_done <= 1'b1;
      lat <= (state == WAIT) ? lat + 2'd1 : 2'd0;
      tick_pend <= auto_en && (tick || (tick_pend && !take_auto));
      pattern <= take_auto ? pattern_rot : pattern;
      s1_chipselect <= take_auto || take_cmd;
      s1_write_n <= !(take_auto || (take_cmd && cmd_write));
      s1_address <= take_auto ? PIO_ADDR_DATA : take_cmd ? cmd_addr : s1_address;
      s1_writedata <= take_auto ? 32'(pattern_rot) : take_cmd ? cmd_wdata : s1_writedata;
      rsp_valid <= capture;
      rsp_rdata <= capture ? s1_readdata : rsp_rdata;
    end
endmodule
